// File: rtl/sample_buf_pkg.sv
// Shared definitions for the sample capture buffer read-out path.
//   NUM_CH  : channels in the capture buffer
//   BITS    : bits per sample (one sample per output byte)
//   SAMPLES : samples per channel window, oldest at the low byte
//   HDR_TAG : upper nibble tag of every frame header byte
//   state_t : read-out sequencer states
package sample_buf_pkg;
  localparam int NUM_CH  = 7;
  localparam int BITS    = 8;
  localparam int SAMPLES = 10;

  localparam logic [7:0] HDR_TAG = 8'hA0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HDR  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5
  } state_t;
endpackage

// File: rtl/sample_window_reader_lowest_set_bit.sv
// lowest_set_bit: priority encoder returning the index of the lowest set bit.
//   vec : input vector
//   idx : index of the lowest set bit (0 when vec is empty)
//   any : vec has at least one bit set
module lowest_set_bit #(
  parameter int N  = 7,
  parameter int IW = 3
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign any = |vec;
endmodule

// File: rtl/sample_window_reader.sv
// sample_window_reader: snapshots each requested channel window from the capture
// buffer and streams it as a byte frame {header, samples oldest-first, checksum}.
//   clk, reset        : clock, async active-high reset
//   start, ch_mask    : read request and channel set (sampled in IDLE)
//   win_data          : flattened capture buffers, channel c at [c*SAMPLES*BITS +: SAMPLES*BITS]
//   hold, busy        : freeze request to the writer / request in progress
//   out_data/valid/ready/last : byte stream, last marks a frame's checksum byte
//   done              : one-cycle completion pulse
module sample_window_reader
  import sample_buf_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_CH-1:0]              ch_mask,
  input  logic [NUM_CH*SAMPLES*BITS-1:0] win_data,
  output logic                           hold,
  output logic                           busy,
  output logic [7:0]                     out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           done
);
  localparam int WIN_W = SAMPLES * BITS;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = $clog2(SAMPLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  state_t state, state_nxt;

  logic [NUM_CH-1:0]              pending;
  logic [SAMPLES-1:0][BITS-1:0]   snap;
  logic [IDX_W-1:0]               idx;
  logic [7:0]                     csum;
  logic [CH_W-1:0]                cur_ch;

  logic [NUM_CH-1:0][WIN_W-1:0]   win;
  logic [CH_W-1:0]                pick;
  logic                           pick_any;
  logic                           xfer;

  // Per-channel view of the flattened buffer bus.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_win
    assign win[c] = win_data[c*WIN_W +: WIN_W];
  end

  lowest_set_bit #(.N(NUM_CH), .IW(CH_W)) u_lsb (
    .vec (pending),
    .idx (pick),
    .any (pick_any)
  );

  assign xfer = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = pick_any ? HDR : DONE;
      HDR:  if (xfer) state_nxt = DATA;
      DATA: if (xfer && idx == LAST_IDX) state_nxt = CSUM;
      CSUM: if (xfer) state_nxt = LOAD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from state so reset drops them without a clock edge.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'h00;
    done      = 1'b0;
    case (state)
      HDR: begin
        out_valid = 1'b1;
        out_data  = HDR_TAG | 8'(cur_ch);
      end
      DATA: begin
        out_valid = 1'b1;
        out_data  = snap[idx];
      end
      CSUM: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = csum;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign hold = busy;

  // Datapath: pending set, snapshot, byte index, checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      snap    <= '0;
      idx     <= '0;
      csum    <= 8'h00;
      cur_ch  <= '0;
    end else begin
      case (state)
        IDLE: if (start) pending <= ch_mask;
        LOAD: if (pick_any) begin
          cur_ch        <= pick;
          snap          <= win[pick];
          pending[pick] <= 1'b0;
          idx           <= '0;
          csum          <= 8'h00;
        end
        DATA: if (xfer) begin
          csum <= csum + snap[idx];
          idx  <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_window_reader.sv
module tb_sample_window_reader;
  import sample_buf_pkg::*;

  logic                           clk = 1'b0;
  logic                           reset;
  logic                           start;
  logic [NUM_CH-1:0]              ch_mask;
  logic [NUM_CH*SAMPLES*BITS-1:0] win_data;
  logic                           hold, busy, out_valid, out_last, done;
  logic [7:0]                     out_data;
  logic                           out_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] win_b [NUM_CH][SAMPLES];
  logic [8:0] exp_q [$];   // {last, data}
  logic [8:0] obs_q [$];
  int         stab_bad;
  bit         done_hold;

  sample_window_reader dut (
    .clk(clk), .reset(reset), .start(start), .ch_mask(ch_mask), .win_data(win_data),
    .hold(hold), .busy(busy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic pack_win();
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < SAMPLES; s++)
        win_data[(c*SAMPLES+s)*8 +: 8] = win_b[c][s];
  endtask

  task automatic rand_win();
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < SAMPLES; s++)
        win_b[c][s] = 8'($urandom);
    pack_win();
  endtask

  // Reference: the frames a request must produce, built from the frame rules.
  task automatic build_exp(input logic [NUM_CH-1:0] mask);
    int sum;
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        exp_q.push_back({1'b0, 8'hA0 + 8'(c)});
        sum = 0;
        for (int s = 0; s < SAMPLES; s++) begin
          exp_q.push_back({1'b0, win_b[c][s]});
          sum += int'(win_b[c][s]);
        end
        exp_q.push_back({1'b1, 8'(sum % 256)});
      end
    end
  endtask

  // Issues one request and records every transferred byte until done or timeout.
  task automatic run_stream(input logic [NUM_CH-1:0] mask, input int rdy_pct,
                            input bit extra, output int done_cyc, output bit first_ok);
    bit         prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    obs_q.delete();
    stab_bad   = 0;
    done_cyc   = -1;
    done_hold  = 0;
    prev_stall = 0;
    prev_d     = 8'h00;
    prev_l     = 1'b0;
    @(negedge clk);
    ch_mask = mask;
    start   = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    first_ok = (out_valid === 1'b0) && (busy === 1'b1) && (hold === 1'b1);
    for (int cyc = 1; cyc < 3000; cyc++) begin
      if (done === 1'b1) begin
        done_cyc  = cyc;
        done_hold = (hold === 1'b1);
        break;
      end
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l))
        stab_bad++;
      out_ready = ($urandom_range(99) < rdy_pct);
      start     = extra && ($urandom_range(3) == 0);
      if (out_valid === 1'b1 && out_ready) obs_q.push_back({out_last, out_data});
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ch_mask = '0; out_ready = 1'b0;
    rand_win();
    @(negedge clk);
    checks++;
    if ({hold, busy, out_valid, out_last, done} !== 5'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got h%b b%b v%b l%b d%b data %h, want all 0", hold, busy, out_valid, out_last, done, out_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    int dc; bit fo;
    rand_win();
    for (int s = 0; s < SAMPLES; s++) win_b[0][s] = 8'(s + 1);
    pack_win();
    build_exp(7'b0000001);
    run_stream(7'b0000001, 100, 0, dc, fo);
    checks++;
    if (!fo) begin errors++; $display("FAIL single_latency: header not absent/busy in LOAD cycle"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL single_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== 9'h137) begin
      errors++; $display("FAIL single_csum: want last=1 data 37");
    end
    checks++;
    if (dc != SAMPLES + 5) begin errors++; $display("FAIL single_done_cycle: got %0d want %0d", dc, SAMPLES + 5); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_after_done: done %b busy %b want 0 0", done, busy); end
  endtask

  task automatic test_two();
    int dc; bit fo;
    rand_win();
    build_exp(7'b1000100);
    run_stream(7'b1000100, 100, 0, dc, fo);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL two_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL two_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    // Full rate: frames of SAMPLES+2 bytes, one LOAD gap each, plus initial LOAD and DONE.
    checks++;
    if (dc != 2*(SAMPLES+3) + 2) begin errors++; $display("FAIL two_done_cycle: got %0d want %0d", dc, 2*(SAMPLES+3)+2); end
  endtask

  task automatic test_backpressure();
    int dc; bit fo;
    build_exp(7'b1000100);
    run_stream(7'b1000100, 50, 0, dc, fo);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (stab_bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stall cycles, want 0", stab_bad); end
    checks++;
    if (dc < 0) begin errors++; $display("FAIL bp_timeout: done never seen"); end
  endtask

  task automatic test_empty();
    int dc; bit fo;
    run_stream('0, 100, 0, dc, fo);
    checks++;
    if (dc != 2) begin errors++; $display("FAIL empty_done_cycle: got %0d want 2", dc); end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL empty_bytes: got %0d bytes want 0", obs_q.size()); end
    checks++;
    if (!fo || !done_hold) begin errors++; $display("FAIL empty_hold: load %b done %b want 1 1", fo, done_hold); end
  endtask

  task automatic test_wrap_extra();
    int dc; bit fo;
    rand_win();
    for (int s = 0; s < SAMPLES; s++) win_b[4][s] = 8'hFF;
    pack_win();
    build_exp(7'b0010000);
    run_stream(7'b0010000, 70, 1, dc, fo);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== 9'h1F6) begin errors++; $display("FAIL wrap_csum: want last=1 data F6"); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL no_requeue[%0d]: busy %b valid %b want 0 0", k, busy, out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    int n; int dc; bit fo; bit saw_done;
    rand_win();
    n = 0; saw_done = 0;
    @(negedge clk);
    ch_mask = 7'b0001000; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done === 1'b1) saw_done = 1;
      if (out_valid === 1'b1) n++;
      if (n == 4) break;
      @(negedge clk);
    end
    checks++;
    if (n != 4 || out_data !== win_b[3][2]) begin errors++; $display("FAIL mid_reach: n %0d data %h want 4 %h", n, out_data, win_b[3][2]); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, hold, busy, done} !== 4'b0) begin errors++; $display("FAIL mid_reset: v%b h%b b%b d%b want 0", out_valid, hold, busy, done); end
    @(negedge clk);
    checks++;
    if (saw_done || done !== 1'b0) begin errors++; $display("FAIL mid_no_done: done pulsed, want none"); end
    reset = 1'b0;
    build_exp(7'b0101000);
    run_stream(7'b0101000, 60, 0, dc, fo);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_backpressure();
    test_empty();
    test_wrap_extra();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
